// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded instruction and operands, with write-back
// bypass, load-use bubble insertion, EX back-pressure hold and branch flush.
module id_ex_stage_reg #(
  parameter int CTRL_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ID_VALID,
  input  logic [31:0]            ID_PC,
  input  logic [4:0]             ID_RS1_ADDR,
  input  logic [4:0]             ID_RS2_ADDR,
  input  logic                   ID_USES_RS1,
  input  logic                   ID_USES_RS2,
  input  logic [31:0]            ID_RS1_DATA,
  input  logic [31:0]            ID_RS2_DATA,
  input  logic [31:0]            ID_IMM,
  input  logic [4:0]             ID_RD_ADDR,
  input  logic                   ID_REG_WRITE,
  input  logic                   ID_MEM_READ,
  input  logic [CTRL_W-1:0]      ID_CTRL,
  input  logic                   WB_WRITE_ENABLE,
  input  logic [4:0]             WB_WRITE_ADDR,
  input  logic [31:0]            WB_WRITE_DATA,
  input  logic                   EX_BUSY,
  input  logic                   FLUSH,
  output logic                   EX_VALID,
  output logic [31:0]            EX_PC,
  output logic [4:0]             EX_RS1_ADDR,
  output logic [4:0]             EX_RS2_ADDR,
  output logic [31:0]            EX_RS1_DATA,
  output logic [31:0]            EX_RS2_DATA,
  output logic [31:0]            EX_IMM,
  output logic [4:0]             EX_RD_ADDR,
  output logic                   EX_REG_WRITE,
  output logic                   EX_MEM_READ,
  output logic [CTRL_W-1:0]      EX_CTRL,
  output logic                   STALL_ID,
  output logic [STALL_CNT_W-1:0] STALL_CYCLES
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_BUBBLE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [31:0]            ex_pc_q, ex_pc_d;
  logic [4:0]             ex_rs1_addr_q, ex_rs1_addr_d;
  logic [4:0]             ex_rs2_addr_q, ex_rs2_addr_d;
  logic [31:0]            ex_rs1_data_q, ex_rs1_data_d;
  logic [31:0]            ex_rs2_data_q, ex_rs2_data_d;
  logic [31:0]            ex_imm_q, ex_imm_d;
  logic [4:0]             ex_rd_addr_q, ex_rd_addr_d;
  logic                   ex_reg_write_q, ex_reg_write_d;
  logic                   ex_mem_read_q, ex_mem_read_d;
  logic [CTRL_W-1:0]      ex_ctrl_q, ex_ctrl_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   load_use;
  logic                   stall_id;

  // The register file is read and written in the same cycle, so a pending write must win.
  function automatic logic [31:0] sel_operand(input logic [4:0]  addr,
                                              input logic [31:0] rf_data,
                                              input logic        wb_en,
                                              input logic [4:0]  wb_addr,
                                              input logic [31:0] wb_data);
    if (addr == 5'd0)                   return 32'd0;
    else if (wb_en && wb_addr == addr)  return wb_data;
    else                                return rf_data;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    else      return cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    load_use = ex_valid_q && ex_mem_read_q && (ex_rd_addr_q != 5'd0) && ID_VALID &&
               (state_q != S_BUBBLE) &&
               ((ID_USES_RS1 && ID_RS1_ADDR == ex_rd_addr_q) ||
                (ID_USES_RS2 && ID_RS2_ADDR == ex_rd_addr_q));
    stall_id = !FLUSH && (EX_BUSY || load_use);

    state_d        = state_q;
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_rs1_addr_d  = ex_rs1_addr_q;
    ex_rs2_addr_d  = ex_rs2_addr_q;
    ex_rs1_data_d  = ex_rs1_data_q;
    ex_rs2_data_d  = ex_rs2_data_q;
    ex_imm_d       = ex_imm_q;
    ex_rd_addr_d   = ex_rd_addr_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_ctrl_d      = ex_ctrl_q;

    if (FLUSH) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      state_d        = S_RUN;
    end else if (EX_BUSY) begin
      state_d = S_HOLD;
    end else if (load_use) begin
      // Bubble: only the side-effect bits matter, payload fields are left as they were.
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      state_d        = S_BUBBLE;
    end else begin
      ex_valid_d     = ID_VALID;
      ex_pc_d        = ID_PC;
      ex_rs1_addr_d  = ID_RS1_ADDR;
      ex_rs2_addr_d  = ID_RS2_ADDR;
      ex_rs1_data_d  = sel_operand(ID_RS1_ADDR, ID_RS1_DATA, WB_WRITE_ENABLE,
                                   WB_WRITE_ADDR, WB_WRITE_DATA);
      ex_rs2_data_d  = sel_operand(ID_RS2_ADDR, ID_RS2_DATA, WB_WRITE_ENABLE,
                                   WB_WRITE_ADDR, WB_WRITE_DATA);
      ex_imm_d       = ID_IMM;
      ex_rd_addr_d   = ID_RD_ADDR;
      ex_reg_write_d = ID_REG_WRITE && ID_VALID;
      ex_mem_read_d  = ID_MEM_READ && ID_VALID;
      ex_ctrl_d      = ID_CTRL;
      state_d        = S_RUN;
    end

    stall_cycles_d = stall_id ? sat_inc(stall_cycles_q) : stall_cycles_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= S_RUN;
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rs1_addr_q  <= '0;
      ex_rs2_addr_q  <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_rd_addr_q   <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_ctrl_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_addr_q  <= ex_rs1_addr_d;
      ex_rs2_addr_q  <= ex_rs2_addr_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_addr_q   <= ex_rd_addr_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_ctrl_q      <= ex_ctrl_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign EX_VALID     = ex_valid_q;
  assign EX_PC        = ex_pc_q;
  assign EX_RS1_ADDR  = ex_rs1_addr_q;
  assign EX_RS2_ADDR  = ex_rs2_addr_q;
  assign EX_RS1_DATA  = ex_rs1_data_q;
  assign EX_RS2_DATA  = ex_rs2_data_q;
  assign EX_IMM       = ex_imm_q;
  assign EX_RD_ADDR   = ex_rd_addr_q;
  assign EX_REG_WRITE = ex_reg_write_q;
  assign EX_MEM_READ  = ex_mem_read_q;
  assign EX_CTRL      = ex_ctrl_q;
  assign STALL_ID     = stall_id;
  assign STALL_CYCLES = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: a reference model predicts the EX register contents
// and stall count for each edge; predictions are queued and popped after the edge.
module tb_id_ex_stage_reg;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              ID_VALID, ID_USES_RS1, ID_USES_RS2, ID_REG_WRITE, ID_MEM_READ;
  logic [31:0]       ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]        ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic [CTRL_W-1:0] ID_CTRL;
  logic              WB_WRITE_ENABLE;
  logic [4:0]        WB_WRITE_ADDR;
  logic [31:0]       WB_WRITE_DATA;
  logic              EX_BUSY, FLUSH;
  logic              EX_VALID, EX_REG_WRITE, EX_MEM_READ, STALL_ID;
  logic [31:0]       EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM;
  logic [4:0]        EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR;
  logic [CTRL_W-1:0] EX_CTRL;
  logic [CNT_W-1:0]  STALL_CYCLES;

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .STALL_CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .ID_RS1_DATA(ID_RS1_DATA),
    .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_CTRL(ID_CTRL),
    .WB_WRITE_ENABLE(WB_WRITE_ENABLE), .WB_WRITE_ADDR(WB_WRITE_ADDR),
    .WB_WRITE_DATA(WB_WRITE_DATA), .EX_BUSY(EX_BUSY), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_RS1_ADDR(EX_RS1_ADDR), .EX_RS2_ADDR(EX_RS2_ADDR),
    .EX_RS1_DATA(EX_RS1_DATA), .EX_RS2_DATA(EX_RS2_DATA), .EX_IMM(EX_IMM),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
    .EX_CTRL(EX_CTRL), .STALL_ID(STALL_ID), .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              known;
    logic              valid;
    logic [31:0]       pc;
    logic [4:0]        rs1a, rs2a;
    logic [31:0]       rs1d, rs2d, imm;
    logic [4:0]        rd;
    logic              rw, mr;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   mst;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (WB_WRITE_ENABLE && WB_WRITE_ADDR == a) return WB_WRITE_DATA;
    return d;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m.known = 1'b1;
    mst = 0;
    sb_q.delete();
  endtask

  task automatic step();
    logic lu, st;
    exp_t n, e;
    #1;
    lu = m.valid && m.mr && (m.rd != 5'd0) && ID_VALID && (mst != 2) &&
         ((ID_USES_RS1 && ID_RS1_ADDR == m.rd) || (ID_USES_RS2 && ID_RS2_ADDR == m.rd));
    st = !FLUSH && (EX_BUSY || lu);
    chk("stall_id", STALL_ID, st);
    n = m;
    if (FLUSH) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.known = 0; mst = 0;
    end else if (EX_BUSY) begin
      mst = 1;
    end else if (lu) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.known = 0; mst = 2;
    end else begin
      n.known = 1; n.valid = ID_VALID; n.pc = ID_PC;
      n.rs1a = ID_RS1_ADDR; n.rs2a = ID_RS2_ADDR;
      n.rs1d = ref_op(ID_RS1_ADDR, ID_RS1_DATA);
      n.rs2d = ref_op(ID_RS2_ADDR, ID_RS2_DATA);
      n.imm = ID_IMM; n.rd = ID_RD_ADDR;
      n.rw = ID_REG_WRITE && ID_VALID; n.mr = ID_MEM_READ && ID_VALID;
      n.ctrl = ID_CTRL; mst = 0;
    end
    if (st && n.cnt != {CNT_W{1'b1}}) n.cnt = n.cnt + 1'b1;
    m = n;
    sb_q.push_back(n);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("ex_valid", EX_VALID, e.valid);
    chk("ex_reg_write", EX_REG_WRITE, e.rw);
    chk("ex_mem_read", EX_MEM_READ, e.mr);
    chk("stall_cycles", STALL_CYCLES, e.cnt);
    if (e.known) begin
      chk("ex_pc", EX_PC, e.pc);
      chk("ex_rs1_addr", EX_RS1_ADDR, e.rs1a);
      chk("ex_rs2_addr", EX_RS2_ADDR, e.rs2a);
      chk("ex_rs1_data", EX_RS1_DATA, e.rs1d);
      chk("ex_rs2_data", EX_RS2_DATA, e.rs2d);
      chk("ex_imm", EX_IMM, e.imm);
      chk("ex_rd_addr", EX_RD_ADDR, e.rd);
      chk("ex_ctrl", EX_CTRL, e.ctrl);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic u1, input logic u2);
    ID_VALID = v; ID_RS1_ADDR = rs1; ID_RS2_ADDR = rs2; ID_RD_ADDR = rd;
    ID_REG_WRITE = rw; ID_MEM_READ = mr; ID_USES_RS1 = u1; ID_USES_RS2 = u2;
    ID_PC = $urandom; ID_RS1_DATA = $urandom; ID_RS2_DATA = $urandom;
    ID_IMM = $urandom; ID_CTRL = CTRL_W'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, EX_VALID, 0);
    chk({tag, "_pc"}, EX_PC, 0);
    chk({tag, "_rs1_data"}, EX_RS1_DATA, 0);
    chk({tag, "_rs2_data"}, EX_RS2_DATA, 0);
    chk({tag, "_imm"}, EX_IMM, 0);
    chk({tag, "_rd"}, EX_RD_ADDR, 0);
    chk({tag, "_rw"}, EX_REG_WRITE, 0);
    chk({tag, "_mr"}, EX_MEM_READ, 0);
    chk({tag, "_ctrl"}, EX_CTRL, 0);
    chk({tag, "_cnt"}, STALL_CYCLES, 0);
  endtask

  initial begin
    RESET = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    WB_WRITE_ENABLE = 0; WB_WRITE_ADDR = 0; WB_WRITE_DATA = 0;
    EX_BUSY = 0; FLUSH = 0;
    #12;
    chk_all_zero("reset");
    RESET = 1'b1;
    model_reset();

    // addi x5, x1, 4
    drive_id(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 0);
    ID_RS1_DATA = 32'h10; ID_IMM = 32'd4;
    step();
    chk("pass_rs1", EX_RS1_DATA, 32'h10);
    chk("pass_imm", EX_IMM, 32'd4);
    chk("pass_valid", EX_VALID, 1);

    // write-back bypass on x7, then x0 stays zero even when written
    drive_id(1, 5'd7, 5'd2, 5'd6, 1, 0, 1, 1);
    ID_RS1_DATA = 32'h1111;
    WB_WRITE_ENABLE = 1; WB_WRITE_ADDR = 5'd7; WB_WRITE_DATA = 32'hBEEF;
    step();
    chk("bypass_rs1", EX_RS1_DATA, 32'hBEEF);
    drive_id(1, 5'd0, 5'd0, 5'd6, 1, 0, 1, 1);
    ID_RS1_DATA = 32'h1234; ID_RS2_DATA = 32'h5555;
    WB_WRITE_ADDR = 5'd0; WB_WRITE_DATA = 32'hDEAD;
    step();
    chk("x0_rs1", EX_RS1_DATA, 0);
    chk("x0_rs2", EX_RS2_DATA, 0);
    WB_WRITE_ENABLE = 0;

    // lw x3 followed by add x4, x3, x1
    drive_id(1, 5'd2, 5'd0, 5'd3, 1, 1, 1, 0);
    step();
    drive_id(1, 5'd3, 5'd1, 5'd4, 1, 0, 1, 1);
    step();
    chk("lu_bubble", EX_VALID, 0);
    step();
    chk("lu_add_valid", EX_VALID, 1);
    chk("lu_add_rd", EX_RD_ADDR, 5'd4);
    chk("lu_count", STALL_CYCLES, 4'd1);

    // EX busy for five cycles
    drive_id(1, 5'd1, 5'd2, 5'd8, 1, 0, 1, 1);
    EX_BUSY = 1;
    for (int i = 0; i < 5; i++) step();
    chk("busy_count", STALL_CYCLES, 4'd6);
    EX_BUSY = 0;
    step();

    // flush wins over a simultaneous load-use and busy
    drive_id(1, 5'd2, 5'd0, 5'd9, 1, 1, 1, 0);
    step();
    drive_id(1, 5'd9, 5'd0, 5'd10, 1, 0, 1, 0);
    EX_BUSY = 1; FLUSH = 1;
    step();
    chk("flush_valid", EX_VALID, 0);
    EX_BUSY = 0; FLUSH = 0;
    drive_id(1, 5'd1, 5'd0, 5'd11, 1, 0, 1, 0);
    step();
    chk("post_flush_valid", EX_VALID, 1);

    // asynchronous reset in the middle of a busy hold with a valid EX instruction
    EX_BUSY = 1;
    step();
    step();
    #2;
    RESET = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    RESET = 1'b1;
    model_reset();
    EX_BUSY = 0;
    drive_id(1, 5'd1, 5'd2, 5'd12, 1, 1, 1, 1);
    step();

    // random traffic over a small register window to provoke hazards and bypasses
    for (int i = 0; i < 300; i++) begin
      drive_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
      WB_WRITE_ENABLE = 1'($urandom);
      WB_WRITE_ADDR = 5'($urandom_range(0, 3));
      WB_WRITE_DATA = $urandom;
      EX_BUSY = ($urandom_range(0, 4) == 0);
      FLUSH = ($urandom_range(0, 9) == 0);
      step();
    end

    // saturation of the stall counter
    FLUSH = 0; EX_BUSY = 1;
    for (int i = 0; i < 20; i++) step();
    chk("cnt_saturated", STALL_CYCLES, 4'hF);
    EX_BUSY = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
